// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam logic [3:0]  BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // 10^n, used to derive the largest value the digit field can represent
  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more before the shift.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] adj_c
);

  always_comb begin
    adj_c = digit;
    if (digit >= DIGIT_W'(5)) begin
      adj_c = digit + DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter with start/busy/done handshake.
// Optional build macro BCD_LZ_BLANK_EN blanks leading zero digits with BLANK_CODE.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned DIGITS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [BIN_W-1:0]            bin_in,
  output logic                        busy,
  output logic                        done,
  output logic [DIGIT_W*DIGITS-1:0]   bcd_out,
  output logic                        ovf
);

  localparam int unsigned BCD_W   = DIGIT_W * DIGITS;
  localparam int unsigned CNT_W   = $clog2(BIN_W + 1);
  localparam int unsigned MAX_VAL = pow10(DIGITS) - 1;

  state_t             state;
  logic [BIN_W-1:0]   shift_reg;
  logic [BCD_W-1:0]   scratch;
  logic [CNT_W-1:0]   count;
  logic               ovf_pend;

  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   scratch_nxt;
  logic [BIN_W-1:0]   shift_nxt;
  logic [BCD_W-1:0]   shown;
  logic               last_shift;
  logic               in_ovf;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit (scratch[g*DIGIT_W +: DIGIT_W]),
      .adj_c (adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // One double-dabble step; carry out of the top digit is dropped (mod 10^DIGITS)
  always_comb begin
    scratch_nxt = {adj[BCD_W-2:0], shift_reg[BIN_W-1]};
    shift_nxt   = {shift_reg[BIN_W-2:0], 1'b0};
    last_shift  = (count == CNT_W'(1));
    in_ovf      = (32'(bin_in) > 32'(MAX_VAL));
  end

`ifdef BCD_LZ_BLANK_EN
  logic lead;

  // Blank leading zero digits down to, but never including, digit 0
  always_comb begin
    shown = scratch_nxt;
    lead  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && (scratch_nxt[i*DIGIT_W +: DIGIT_W] == DIGIT_W'(0))) begin
        shown[i*DIGIT_W +: DIGIT_W] = BLANK_CODE;
      end else begin
        lead = 1'b0;
      end
    end
  end
`else
  always_comb begin
    shown = scratch_nxt;
  end
`endif

  // Control FSM; results load on the final shift so DONE already presents them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      scratch   <= '0;
      count     <= '0;
      ovf_pend  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd_out   <= '0;
      ovf       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= SHIFT;
            shift_reg <= bin_in;
            scratch   <= '0;
            count     <= CNT_W'(BIN_W);
            ovf_pend  <= in_ovf;
            busy      <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        SHIFT: begin
          scratch   <= scratch_nxt;
          shift_reg <= shift_nxt;
          count     <= count - CNT_W'(1);
          if (last_shift) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            bcd_out <= shown;
            ovf     <= ovf_pend;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed corner cases plus random values vs. an arithmetic model.
`timescale 1ns/1ps
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [13:0] bin_in;
  logic        busy;
  logic        done;
  logic [15:0] bcd_out;
  logic        ovf;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: decimal digits of (v mod 10000), optionally with leading zeros blanked
  function automatic logic [15:0] ref_bcd(input int unsigned v);
    logic [15:0]  r;
    int unsigned  m;
    m = v % 10000;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(m % 10);
      m = m / 10;
    end
`ifdef BCD_LZ_BLANK_EN
    for (int i = 3; i >= 1; i--) begin
      if (r[i*4 +: 4] != 4'd0) break;
      r[i*4 +: 4] = 4'hF;
    end
`endif
    return r;
  endfunction

  // One conversion; optionally pokes start with bin_in=7 at busy cycle ignore_at
  task automatic convert(input int unsigned v, input int ignore_at);
    int   nb;
    logic got_done;
    logic [15:0] exp;
    exp = ref_bcd(v);
    @(negedge clk);
    bin_in = 14'(v);
    start  = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    nb       = 0;
    got_done = 1'b0;
    for (int k = 0; k < 40 && !got_done; k++) begin
      if (k > 0) @(negedge clk);
      if (done) begin
        got_done = 1'b1;
      end else begin
        if (busy) nb++;
        if (ignore_at != 0 && nb == ignore_at) begin
          start  = 1'b1;
          bin_in = 14'd7;
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk($sformatf("done_seen_%0d", v), 32'(got_done), 32'd1);
    chk($sformatf("busy_len_%0d", v), 32'(nb), 32'd14);
    chk($sformatf("busy_at_done_%0d", v), 32'(busy), 32'd0);
    chk($sformatf("bcd_%0d", v), 32'(bcd_out), 32'(exp));
    chk($sformatf("ovf_%0d", v), 32'(ovf), 32'(v > 9999));
    @(negedge clk);
    chk($sformatf("done_pulse_%0d", v), 32'(done), 32'd0);
    chk($sformatf("bcd_hold_%0d", v), 32'(bcd_out), 32'(exp));
  endtask

  task automatic wait_done(output int t);
    t = -1;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        t = cyc;
        break;
      end
      @(negedge clk);
    end
    chk("wait_done_timeout", 32'(t >= 0), 32'd1);
  endtask

  initial begin
    int t1;
    int t2;
    int nd;
    int unsigned v;

    rst    = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd",  32'(bcd_out), 32'd0);
    chk("rst_ovf",  32'(ovf), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    convert(1234, 0);
    convert(0, 0);
    convert(42, 0);
    convert(9999, 0);
    convert(10000, 0);
    convert(12345, 0);
    convert(16383, 0);
    convert(1, 0);
    convert(1234, 5);

    // start held through DONE: back-to-back conversion, bin_in changed after capture
    @(negedge clk);
    bin_in = 14'd1234;
    start  = 1'b1;
    @(negedge clk);
    bin_in = 14'd5678;
    wait_done(t1);
    chk("b2b_first", 32'(bcd_out), 32'(ref_bcd(1234)));
    @(negedge clk);
    chk("b2b_rebusy", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(t2);
    chk("b2b_spacing", 32'(t2 - t1), 32'd15);
    chk("b2b_second", 32'(bcd_out), 32'(ref_bcd(5678)));
    repeat (2) @(negedge clk);

    for (int n = 0; n < 25; n++) begin
      v = $urandom_range(16383, 0);
      convert(v, 0);
    end

    // async reset in the middle of a conversion
    convert(12345, 0);
    @(negedge clk);
    bin_in = 14'd9999;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_bcd",  32'(bcd_out), 32'd0);
    chk("mid_rst_ovf",  32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nd  = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("no_done_after_rst", 32'(nd), 32'd0);
    chk("bcd_after_rst", 32'(bcd_out), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
